// File: rtl/axis_sink_serializer.sv
// Packet FIFO followed by a byte serializer: each buffered PKT_WIDTH-bit packet
// is emitted as an 8-bit AXI-Stream, most significant byte first, tlast on the final byte.
module axis_sink_serializer #(
  parameter int PKT_WIDTH = 16,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PKT_WIDTH-1:0]         s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [7:0]                   m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int NBYTES = PKT_WIDTH / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  logic [PKT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  state_t               state;
  logic [IDX_W-1:0]     index;
  logic [PKT_WIDTH-1:0] shreg;

  logic push;
  logic pop;
  logic last_byte;
  logic byte_hs;

  // Readiness comes only from the registered count, so there is no path from m_axis_tready.
  assign s_axis_tready = !rst && (count != CNT_W'(DEPTH));
  assign push          = s_axis_tvalid && s_axis_tready;
  assign last_byte     = (index == IDX_W'(NBYTES - 1));
  assign byte_hs       = (state == SEND) && m_axis_tready;
  assign pop           = (count != '0) && ((state == IDLE) || (byte_hs && last_byte));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // On the last byte the next packet is loaded in the same edge, so streams have no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      index <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg <= mem[rd_ptr];
            index <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            if (!last_byte) begin
              shreg <= shreg << 8;
              index <= index + IDX_W'(1);
            end else if (pop) begin
              shreg <= mem[rd_ptr];
              index <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_axis_tvalid = !rst && (state == SEND);
  assign m_axis_tlast  = !rst && (state == SEND) && last_byte;
  assign m_axis_tdata  = rst ? 8'h00 : shreg[PKT_WIDTH-1 -: 8];
  assign level         = rst ? '0 : count;

endmodule

// File: tb/tb_axis_sink_serializer.sv
// Directed bench for axis_sink_serializer: a 16-bit/depth-4 instance and an
// 8-bit/depth-2 instance, checked with immediate assertions against hand-computed values.
module tb_axis_sink_serializer;

  logic        clk;
  logic        rst;

  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [2:0]  level;

  logic [7:0]  n_s_tdata;
  logic        n_s_tvalid;
  logic        n_s_tready;
  logic [7:0]  n_m_tdata;
  logic        n_m_tvalid;
  logic        n_m_tready;
  logic        n_m_tlast;
  logic [1:0]  n_level;

  int checks = 0;
  int errors = 0;

  logic [15:0] push_q[$];
  logic [7:0]  exp_bytes[$];
  logic        exp_last[$];

  axis_sink_serializer #(.PKT_WIDTH(16), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .level         (level)
  );

  axis_sink_serializer #(.PKT_WIDTH(8), .DEPTH(2)) dut_narrow (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (n_s_tdata),
    .s_axis_tvalid (n_s_tvalid),
    .s_axis_tready (n_s_tready),
    .m_axis_tdata  (n_m_tdata),
    .m_axis_tvalid (n_m_tvalid),
    .m_axis_tready (n_m_tready),
    .m_axis_tlast  (n_m_tlast),
    .level         (n_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drives push_q into the wide instance while checking every transferred byte
  // against exp_bytes/exp_last; optionally requires valid on every cycle once streaming starts.
  task automatic applyStimulus(input string name, input int max_cycles, input bit no_bubble);
    int pi = 0;
    int nb = 0;
    bit started = 0;
    for (int c = 0; c < max_cycles && (nb < exp_bytes.size() || pi < push_q.size()); c++) begin
      if (pi < push_q.size()) begin
        s_tvalid = 1'b1;
        s_tdata  = push_q[pi];
      end else begin
        s_tvalid = 1'b0;
      end
      #1;
      if (m_tvalid && m_tready) begin
        if (nb < exp_bytes.size()) begin
          checkOutput($sformatf("%s_byte%0d", name, nb), m_tdata, exp_bytes[nb]);
          checkOutput($sformatf("%s_last%0d", name, nb), m_tlast, exp_last[nb]);
        end else begin
          checkOutput($sformatf("%s_extra_byte", name), m_tvalid, 0);
        end
        started = 1;
        nb++;
      end else if (no_bubble && started && nb < exp_bytes.size()) begin
        checkOutput($sformatf("%s_bubble%0d", name, nb), m_tvalid, 1);
      end
      if (s_tvalid && s_tready) pi++;
      tick();
    end
    s_tvalid = 1'b0;
    checkOutput($sformatf("%s_byte_count", name), nb, exp_bytes.size());
    checkOutput($sformatf("%s_push_count", name), pi, push_q.size());
  endtask

  task automatic applyStimulusNarrow(input string name, input int max_cycles, input bit no_bubble);
    int pi = 0;
    int nb = 0;
    bit started = 0;
    for (int c = 0; c < max_cycles && (nb < exp_bytes.size() || pi < push_q.size()); c++) begin
      if (pi < push_q.size()) begin
        n_s_tvalid = 1'b1;
        n_s_tdata  = push_q[pi][7:0];
      end else begin
        n_s_tvalid = 1'b0;
      end
      #1;
      if (n_m_tvalid && n_m_tready) begin
        if (nb < exp_bytes.size()) begin
          checkOutput($sformatf("%s_byte%0d", name, nb), n_m_tdata, exp_bytes[nb]);
          checkOutput($sformatf("%s_last%0d", name, nb), n_m_tlast, exp_last[nb]);
        end else begin
          checkOutput($sformatf("%s_extra_byte", name), n_m_tvalid, 0);
        end
        started = 1;
        nb++;
      end else if (no_bubble && started && nb < exp_bytes.size()) begin
        checkOutput($sformatf("%s_bubble%0d", name, nb), n_m_tvalid, 1);
      end
      if (n_s_tvalid && n_s_tready) pi++;
      tick();
    end
    n_s_tvalid = 1'b0;
    checkOutput($sformatf("%s_byte_count", name), nb, exp_bytes.size());
    checkOutput($sformatf("%s_push_count", name), pi, push_q.size());
  endtask

  initial begin
    logic [15:0] fill [6];
    int pi;

    rst        = 1'b1;
    s_tdata    = '0;
    s_tvalid   = 1'b0;
    m_tready   = 1'b0;
    n_s_tdata  = '0;
    n_s_tvalid = 1'b0;
    n_m_tready = 1'b0;
    fill = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606};

    // Reset state
    tick();
    tick();
    checkOutput("rst_s_tready", s_tready, 0);
    checkOutput("rst_m_tvalid", m_tvalid, 0);
    checkOutput("rst_m_tlast", m_tlast, 0);
    checkOutput("rst_m_tdata", m_tdata, 8'h00);
    checkOutput("rst_level", level, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_s_tready", s_tready, 1);
    checkOutput("post_rst_m_tvalid", m_tvalid, 0);

    // Single packet, downstream always ready
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 16'hA55A;
    tick();
    s_tvalid = 1'b0;
    checkOutput("t1_not_yet_valid", m_tvalid, 0);
    checkOutput("t1_level_queued", level, 1);
    tick();
    checkOutput("t1_first_valid", m_tvalid, 1);
    checkOutput("t1_first_byte", m_tdata, 8'hA5);
    checkOutput("t1_first_last", m_tlast, 0);
    checkOutput("t1_level_popped", level, 0);
    tick();
    checkOutput("t1_second_byte", m_tdata, 8'h5A);
    checkOutput("t1_second_last", m_tlast, 1);
    tick();
    checkOutput("t1_idle_valid", m_tvalid, 0);
    checkOutput("t1_idle_level", level, 0);

    // Backpressure holds the first byte stable
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 16'hA55A;
    tick();
    s_tvalid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t2_hold_valid%0d", i), m_tvalid, 1);
      checkOutput($sformatf("t2_hold_data%0d", i), m_tdata, 8'hA5);
      checkOutput($sformatf("t2_hold_last%0d", i), m_tlast, 0);
      tick();
    end
    m_tready = 1'b1;
    #1;
    checkOutput("t2_release_data", m_tdata, 8'hA5);
    tick();
    checkOutput("t2_after_data", m_tdata, 8'h5A);
    checkOutput("t2_after_last", m_tlast, 1);
    tick();
    checkOutput("t2_idle_valid", m_tvalid, 0);

    // Fill: one packet in the serializer plus four in the FIFO
    m_tready = 1'b0;
    pi = 0;
    for (int c = 0; c < 8; c++) begin
      s_tvalid = 1'b1;
      s_tdata  = fill[pi];
      #1;
      if (s_tready && pi < 5) pi++;
      tick();
    end
    checkOutput("t3_accepted", pi, 5);
    checkOutput("t3_level_full", level, 4);
    checkOutput("t3_s_tready_full", s_tready, 0);
    checkOutput("t3_head_valid", m_tvalid, 1);
    checkOutput("t3_head_data", m_tdata, 8'h01);
    push_q    = '{16'h0606};
    exp_bytes = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04, 8'h05, 8'h05, 8'h06, 8'h06};
    exp_last  = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    m_tready  = 1'b1;
    applyStimulus("t3", 30, 1'b1);
    checkOutput("t3_level_empty", level, 0);
    checkOutput("t3_idle_valid", m_tvalid, 0);

    // Back-to-back streaming without bubbles
    push_q    = '{16'h1122, 16'h3344, 16'h5566};
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_last  = '{0, 1, 0, 1, 0, 1};
    applyStimulus("t4", 20, 1'b1);
    checkOutput("t4_idle_valid", m_tvalid, 0);

    // Reset mid-packet with two packets queued
    m_tready = 1'b0;
    push_q   = '{16'hA55A, 16'h1111, 16'h2222};
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = push_q[i];
      tick();
    end
    s_tvalid = 1'b0;
    checkOutput("t5_level_queued", level, 2);
    checkOutput("t5_head_data", m_tdata, 8'hA5);
    m_tready = 1'b1;
    tick();
    checkOutput("t5_second_pending", m_tdata, 8'h5A);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_valid", m_tvalid, 0);
    checkOutput("t5_rst_s_tready", s_tready, 0);
    checkOutput("t5_rst_level", level, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("t5_after_valid", m_tvalid, 0);
    checkOutput("t5_after_level", level, 0);
    checkOutput("t5_after_s_tready", s_tready, 1);
    push_q    = '{16'hBEEF};
    exp_bytes = '{8'hBE, 8'hEF};
    exp_last  = '{0, 1};
    applyStimulus("t5", 20, 1'b1);
    checkOutput("t5_idle_valid", m_tvalid, 0);

    // Single-byte packets on the narrow instance
    n_m_tready = 1'b1;
    push_q     = '{16'h007F, 16'h0080, 16'h0000};
    exp_bytes  = '{8'h7F, 8'h80, 8'h00};
    exp_last   = '{1, 1, 1};
    applyStimulusNarrow("t6", 20, 1'b1);
    checkOutput("t6_idle_valid", n_m_tvalid, 0);

    // Narrow instance fill exercises pointer wrap past the earlier three pushes
    n_m_tready = 1'b0;
    pi = 0;
    for (int c = 0; c < 6; c++) begin
      n_s_tvalid = 1'b1;
      n_s_tdata  = 8'(pi + 1);
      #1;
      if (n_s_tready && pi < 3) pi++;
      tick();
    end
    checkOutput("t6_fill_accepted", pi, 3);
    checkOutput("t6_fill_level", n_level, 2);
    checkOutput("t6_fill_s_tready", n_s_tready, 0);
    n_m_tready = 1'b1;
    push_q     = '{16'h0004};
    exp_bytes  = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_last   = '{1, 1, 1, 1};
    applyStimulusNarrow("t6w", 20, 1'b1);
    checkOutput("t6_final_level", n_level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_sink_serializer.md
Name: axis_sink_serializer

Overview:
Downstream stage of the AXI-Stream processor's output port. It buffers whole sink packets (PKT_WIDTH bits, byte-multiple, MSB-aligned) in a small FIFO and serializes each one into an 8-bit AXI-Stream byte stream, most significant byte first, with tlast on the final byte. Its byte output feeds the host-link transmitter (UART/USB byte interface), decoupling network timing from the slower link.

Parameters:
PKT_WIDTH, 16, input packet width in bits; must be a multiple of 8 and at least 8; NBYTES = PKT_WIDTH/8.
DEPTH, 4, packet FIFO entries; power of two, at least 2.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
s_axis_tdata  input  PKT_WIDTH  packet from upstream processor.
s_axis_tvalid  input  1  upstream packet valid.
s_axis_tready  output  1  FIFO can accept a packet.
m_axis_tdata  output  8  serialized byte.
m_axis_tvalid  output  1  byte valid.
m_axis_tready  input  1  downstream byte accept.
m_axis_tlast  output  1  high on the last byte of each packet.
level  output  $clog2(DEPTH+1)  FIFO occupancy; excludes the packet held in the serializer.

Behaviour:
- Reset (rst high at an edge): FIFO pointers/count = 0, serializer IDLE, byte index = 0, shift register = 0. While rst is high: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, level=0. rst has priority over every other event. A partially sent packet is dropped and no further bytes of it appear.
- Push: on an edge with s_axis_tvalid && s_axis_tready, write s_axis_tdata at the write pointer and increment it.
- s_axis_tready = !rst && (count != DEPTH). It depends only on registered count, with no combinational path from m_axis_tready. When full, no push occurs even if a pop happens in the same cycle.
- Pointers wrap modulo DEPTH. count is incremented on push only, decremented on pop only, and unchanged on simultaneous push and pop.
- Serializer FSM:
  - IDLE: m_axis_tvalid=0. If count>0, pop the head entry into the shift register, set index=0, go to SEND.
  - SEND:
    - m_axis_tvalid=1.
    - m_axis_tdata = shift register bits [PKT_WIDTH-1 -: 8], i.e. the current MSB byte.
    - m_axis_tlast = (index == NBYTES-1).
    - On handshake with index<NBYTES-1: shift left by 8 and increment index.
    - On handshake with index==NBYTES-1:
      - If count>0, pop the next entry in the same edge, reset index=0 and stay in SEND. There is no bubble between packets.
      - Otherwise go to IDLE.
- AXIS output rule: while m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tlast are held stable. m_axis_tvalid never drops without a handshake, except on rst.
- Latency:
  - Packet accepted at edge t into an empty FIFO with serializer IDLE: first byte valid after edge t+1.
  - With m_axis_tready held high, the packet's last byte transfers at edge t+NBYTES+1.
  - Sustained throughput: 1 byte per cycle.
- Capacity: DEPTH packets in the FIFO plus 1 in the serializer.
- NBYTES=1: every byte has tlast=1, and consecutive packets stream back-to-back.
- Data is treated as opaque bits. There is no sign handling and no padding: upstream supplies MSB-aligned, zero-padded packets.

Test Plan:
1. PKT_WIDTH=16. Push 0xA55A once, m_axis_tready=1: bytes 0xA5 (tlast=0) then 0x5A (tlast=1). First byte valid one edge after accept. level returns to 0.
2. Backpressure: during 1, hold m_axis_tready=0 for 3 cycles on byte 0xA5. tdata=0xA5 and tvalid=1 stay stable, then 0x5A follows after release.
3. Fill:
   - Setup: DEPTH=4, m_axis_tready=0, s_axis_tvalid=1 continuously, packets 0x0101..0x0606.
   - Exactly 5 accepted (1 in serializer, 4 in FIFO); level=4, s_axis_tready=0.
   - Release m_axis_tready: bytes 01 01 02 02 03 03 04 04 05 05 in order, with the 6th packet accepted once space frees.
4. Streaming: 3 packets 0x1122, 0x3344, 0x5566 with m_axis_tready=1. Six consecutive valid bytes 11 22 33 44 55 66, no bubble; tlast on 22, 44, 66.
5. Reset mid-packet: assert rst for 1 cycle after byte 0xA5 of 0xA55A transfers, with 2 packets queued. Next cycle: tvalid=0, level=0, s_axis_tready=0 during reset and 1 after. 0x5A is never emitted. A new packet 0xBEEF then emits BE, EF normally.
6. PKT_WIDTH=8, DEPTH=2. Push 0x7F, 0x80, 0x00 back-to-back: three bytes each with tlast=1, and pointers wrap correctly.
